adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameters SHALL be:
  - NUM_CH, 2, number of IR sensor channels scanned (1..4).
  - SAMPLE_PERIOD, 100000, clk cycles between scan starts.
  - AVG_LOG2, 2, log2 of conversions averaged per channel (0..4).
  - TIMEOUT, 1000, max clk cycles waited for conv_done.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock; all logic on rising edge.
  - reset  in  1  synchronous, active-high reset.
  - enable  in  1  scanning allowed while high.
  - conv_start  out  1  one-cycle conversion request to ADC interface.
  - conv_channel  out  2  channel for current conversion; valid while conv_start=1.
  - conv_done  in  1  one-cycle pulse; conv_data valid this cycle.
  - conv_data  in  16  signed raw ADC sample.
  - out_valid  out  1  one-cycle pulse; averaged result valid.
  - out_data  out  16  signed averaged sample, feeds distance lookup.
  - out_channel  out  2  channel of out_data.
  - busy  out  1  high while a scan is in progress.
  - timeout_err  out  1  sticky: a conversion timed out.
  - overrun  out  1  sticky: a period tick arrived during a scan.

Function
REQ-003 States SHALL be IDLE, WAIT_TICK, START, WAIT_DONE; busy=1 in START and WAIT_DONE only.
REQ-004 Period counter SHALL be held at 0 in IDLE, else count 0..SAMPLE_PERIOD-1 and wrap; tick = counter at SAMPLE_PERIOD-1.
REQ-005 IDLE with enable=1 SHALL go to START with channel 0 (first scan immediate, counter starts at 0 the same edge).
REQ-006 WAIT_TICK on tick SHALL go to START with channel 0, accumulator and sample count cleared.
REQ-007 START SHALL assert conv_start=1 for exactly one cycle with conv_channel=current channel, then go to WAIT_DONE with timeout counter cleared.
REQ-008 WAIT_DONE on conv_done=1 SHALL add sign-extended conv_data into a (16+AVG_LOG2)-bit signed accumulator and increment sample count.
REQ-009 If sample count after that add < 2^AVG_LOG2, next state SHALL be START for the same channel.
REQ-010 On the final sample, out_data SHALL register (accumulator incl. this sample) >>> AVG_LOG2 (arithmetic, floor), truncated to 16 bits; out_channel=channel; out_valid=1 in the cycle after the edge that sampled conv_done.
REQ-011 After the final sample, if channel < NUM_CH-1 the block SHALL go to START with channel+1 and cleared accumulator (conv_start coincides with out_valid); else to WAIT_TICK.
REQ-012 WAIT_DONE SHALL increment the timeout counter each cycle without conv_done; at TIMEOUT-1 it SHALL set timeout_err, discard the channel's accumulator (no out_valid) and advance per REQ-011.
REQ-013 conv_done in the same cycle as the timeout terminal count SHALL win; no timeout recorded.
REQ-014 conv_done outside WAIT_DONE SHALL be ignored.
REQ-015 A tick while busy=1 SHALL set overrun and be dropped; the scan continues, no extra scan queued.
REQ-016 enable=0 in any state SHALL force IDLE next edge: conv_start=0, out_valid=0, accumulator, channel and counters cleared, sticky flags kept; an in-flight conv_done is ignored.
REQ-017 out_data and out_channel SHALL hold their last values between out_valid pulses.

Reset
REQ-018 reset=1 at a rising edge SHALL force IDLE and clear all state; this takes priority over every other input.
REQ-019 Reset values SHALL be conv_start=0, conv_channel=0, out_valid=0, out_data=0, out_channel=0, busy=0, timeout_err=0, overrun=0.
REQ-020 Reset mid-conversion SHALL discard the conversion; a later conv_done SHALL be ignored.

Verification
REQ-021 NUM_CH=2, AVG_LOG2=2; enable=1; ch0 samples 100,101,102,103 -> out_valid once, out_data=101, out_channel=0, one cycle after 4th conv_done.
REQ-022 ch1 samples -5,-5,-5,-6 -> out_data=-6 (0xFFFA), out_channel=1; then WAIT_TICK, busy=0; next conv_start exactly SAMPLE_PERIOD cycles after first scan's conv_start.
REQ-023 TIMEOUT=8, ch0 never done -> timeout_err=1 after 8 cycles in WAIT_DONE; no out_valid for ch0; conv_start with conv_channel=1 follows.
REQ-024 SAMPLE_PERIOD=20, ADC responds after 30 cycles -> overrun=1; scans do not stack; results still correct.
REQ-025 enable dropped in WAIT_DONE, conv_done next cycle -> no out_valid, IDLE; re-enable -> immediate conv_start channel 0.
REQ-026 reset asserted mid-scan -> all outputs at REQ-019 values next cycle; stale conv_done ignored.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Periodic multi-channel ADC scan: issues conversion requests, averages
// 2**AVG_LOG2 samples per channel and reports one result per channel per scan.
module adc_scan_sequencer #(
    parameter int NUM_CH        = 2,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               conv_start,
    output logic [1:0]         conv_channel,
    input  logic               conv_done,
    input  logic signed [15:0] conv_data,
    output logic               out_valid,
    output logic signed [15:0] out_data,
    output logic [1:0]         out_channel,
    output logic               busy,
    output logic               timeout_err,
    output logic               overrun
);

    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] NSAMP    = CW'(2 ** AVG_LOG2);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [1:0]    CH_LAST  = 2'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_TICK = 2'd1;
    localparam logic [1:0] S_START     = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           ch_q, ch_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        per_q, per_d;
    logic [TW-1:0]        to_q, to_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [15:0]   out_data_q, out_data_d;
    logic [1:0]           out_ch_q, out_ch_d;
    logic                 terr_q, terr_d;
    logic                 ovr_q, ovr_d;

    logic                 tick;
    logic                 busy_int;
    logic                 advance;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        cnt_inc;

    assign busy_int = (state_q == S_START) || (state_q == S_WAIT_DONE);
    assign tick     = (state_q != S_IDLE) && (per_q == PER_LAST);
    assign sum      = acc_q + AW'(conv_data);
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        terr_d      = terr_q;
        ovr_d       = ovr_q;
        advance     = 1'b0;
        per_d       = (state_q == S_IDLE || tick) ? '0 : per_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                state_d = S_START;
                ch_d    = '0;
                acc_d   = '0;
                cnt_d   = '0;
            end
            S_WAIT_TICK: begin
                if (tick) begin
                    state_d = S_START;
                    ch_d    = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
                to_d    = '0;
            end
            default: begin
                // A sample arriving on the timeout terminal cycle is still taken.
                if (conv_done) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc < NSAMP) begin
                        state_d = S_START;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = 16'(sum >>> AVG_LOG2);
                        out_ch_d    = ch_q;
                        advance     = 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    advance = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
        endcase

        if (advance) begin
            acc_d = '0;
            cnt_d = '0;
            if (ch_q < CH_LAST) begin
                state_d = S_START;
                ch_d    = ch_q + 2'd1;
            end else begin
                state_d = S_WAIT_TICK;
                ch_d    = '0;
            end
        end

        if (tick && busy_int) ovr_d = 1'b1;

        // Disable aborts everything except the sticky error flags and held result.
        if (!enable) begin
            state_d     = S_IDLE;
            ch_d        = '0;
            acc_d       = '0;
            cnt_d       = '0;
            per_d       = '0;
            to_d        = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            out_ch_d    = out_ch_q;
            terr_d      = terr_q;
            ovr_d       = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            per_q       <= '0;
            to_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            terr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            to_q        <= to_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            terr_q      <= terr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign conv_start   = (state_q == S_START);
    assign conv_channel = ch_q;
    assign busy         = busy_int;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_channel  = out_ch_q;
    assign timeout_err  = terr_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: table-driven scans, timeout/overrun/enable/reset
// corner sequences, then random scans scored against a scan-level model.
module tb_adc_scan_sequencer;

    localparam int NCH  = 2;
    localparam int SP   = 20;
    localparam int ALOG = 2;
    localparam int TO   = 8;
    localparam int NS   = 1 << ALOG;

    logic               clk = 1'b0;
    logic               reset, enable, conv_done;
    logic signed [15:0] conv_data;
    logic               conv_start, out_valid, busy, timeout_err, overrun;
    logic [1:0]         conv_channel, out_channel;
    logic signed [15:0] out_data;

    adc_scan_sequencer #(.NUM_CH(NCH), .SAMPLE_PERIOD(SP), .AVG_LOG2(ALOG), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .conv_start(conv_start), .conv_channel(conv_channel),
        .conv_done(conv_done), .conv_data(conv_data),
        .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
        .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ov_count = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) ov_count <= ov_count + 1;
    end

    int nvec = 0, nfail = 0;
    int next_start, ov_exp = 0, te_exp = 0, ovr_exp = 0;

    typedef struct {
        int smp[8];
        int dly;
        int exp0;
        int exp1;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int favg(input int s);
        return (s >= 0) ? s / NS : -((-s + NS - 1) / NS);
    endfunction

    // One full scan: deliver samples with given response delays, optionally let
    // conversion to_idx time out, and check results plus scan-level timing.
    task automatic scan(input int smp[8], input int dly[8], input int to_idx,
                        input int e0, input int e1);
        int n, ts, s, last, i, m;
        bit timed;
        int ex[2];
        ex[0] = e0; ex[1] = e1;
        n = 0;
        while (!conv_start && n < 200) begin step(); n++; end
        chk("scan_start_cycle", cyc, next_start);
        ts = cyc; last = ts;
        for (int ch = 0; ch < NCH; ch++) begin
            timed = 0;
            for (int k = 0; k < NS; k++) begin
                i = ch * NS + k;
                chk("conv_start", int'(conv_start), 1);
                chk("conv_channel", int'(conv_channel), ch);
                s = cyc;
                step();
                chk("conv_start_pulse", int'(conv_start), 0);
                if (i == to_idx) begin
                    repeat (TO - 1) step();
                    chk("timeout_hold", int'(timeout_err), te_exp);
                    step();
                    te_exp = 1;
                    chk("timeout_set", int'(timeout_err), 1);
                    chk("no_valid_on_timeout", int'(out_valid), 0);
                    last = s + TO;
                    timed = 1;
                    break;
                end
                repeat (dly[i] - 1) step();
                conv_done = 1'b1;
                conv_data = 16'(smp[i]);
                step();
                conv_done = 1'b0;
                last = s + dly[i];
            end
            if (!timed) begin
                chk("out_valid", int'(out_valid), 1);
                chk("out_data", int'(out_data), ex[ch]);
                chk("out_channel", int'(out_channel), ch);
                ov_exp++;
            end
        end
        chk("busy_after_scan", int'(busy), 0);
        step();
        chk("out_valid_count", ov_count, ov_exp);
        if (last - ts >= SP - 1) ovr_exp = 1;
        chk("overrun", int'(overrun), ovr_exp);
        chk("timeout_err", int'(timeout_err), te_exp);
        m = 1;
        while (ts + m * SP - 1 <= last) m++;
        next_start = ts + m * SP;
    endtask

    initial begin
        int d[8], s8[8], toi, sum0, sum1, n;

        tbl[0].smp = '{100, 101, 102, 103, -5, -5, -5, -6};       tbl[0].dly = 1; tbl[0].exp0 = 101;    tbl[0].exp1 = -6;
        tbl[1].smp = '{0, 0, 0, 0, 1, 1, 1, 2};                   tbl[1].dly = 1; tbl[1].exp0 = 0;      tbl[1].exp1 = 1;
        tbl[2].smp = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
        tbl[2].dly = 1; tbl[2].exp0 = 32767; tbl[2].exp1 = -32768;
        tbl[3].smp = '{-1, 0, 0, 0, 3, 0, 0, 0};                  tbl[3].dly = 1; tbl[3].exp0 = -1;     tbl[3].exp1 = 0;
        tbl[4].smp = '{32767, 32767, -32768, -32768, 7, -7, 5, 1}; tbl[4].dly = 1; tbl[4].exp0 = -1;    tbl[4].exp1 = 1;

        reset = 1'b1; enable = 1'b0; conv_done = 1'b0; conv_data = '0;
        repeat (3) step();
        chk("rst_conv_start", int'(conv_start), 0);
        chk("rst_conv_channel", int'(conv_channel), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_channel", int'(out_channel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        repeat (2) step();
        chk("idle_busy", int'(busy), 0);
        chk("idle_conv_start", int'(conv_start), 0);

        enable = 1'b1;
        next_start = cyc + 1;
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < 8; j++) d[j] = tbl[v].dly;
            scan(tbl[v].smp, d, -1, tbl[v].exp0, tbl[v].exp1);
        end

        // Response exactly at the timeout limit is accepted; slow scan overruns.
        s8 = '{10, 20, 30, 40, -1, -2, -3, -4};
        d  = '{TO, 1, 1, 1, 1, 1, 1, 1};
        scan(s8, d, -1, 25, -3);

        // First ch0 conversion never answered.
        s8 = '{0, 0, 0, 0, 8, 8, 8, 9};
        d  = '{1, 1, 1, 1, 1, 1, 1, 1};
        scan(s8, d, 0, 0, 8);

        for (int r = 0; r < 30; r++) begin
            sum0 = 0; sum1 = 0;
            for (int j = 0; j < 8; j++) begin
                s8[j] = int'($urandom_range(0, 65535)) - 32768;
                d[j]  = int'($urandom_range(1, TO));
                if (j < 4) sum0 += s8[j]; else sum1 += s8[j];
            end
            toi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            scan(s8, d, toi, favg(sum0), favg(sum1));
        end

        // Enable dropped mid-conversion with partial accumulation; late done ignored.
        n = 0;
        while (!conv_start && n < 200) begin step(); n++; end
        chk("pre_disable_start", cyc, next_start);
        for (int j = 0; j < 2; j++) begin
            step(); conv_done = 1'b1; conv_data = 16'sd1000; step(); conv_done = 1'b0;
        end
        step();
        enable = 1'b0;
        step();
        chk("disable_busy", int'(busy), 0);
        conv_done = 1'b1; conv_data = 16'sd1234;
        step();
        conv_done = 1'b0;
        chk("disable_no_valid", int'(out_valid), 0);
        chk("disable_no_start", int'(conv_start), 0);
        repeat (3) step();
        chk("disable_valid_count", ov_count, ov_exp);
        chk("disable_overrun_kept", int'(overrun), ovr_exp);
        chk("disable_terr_kept", int'(timeout_err), te_exp);
        enable = 1'b1;
        step();
        chk("reenable_start", int'(conv_start), 1);
        chk("reenable_channel", int'(conv_channel), 0);
        next_start = cyc;
        for (int j = 0; j < 8; j++) d[j] = 1;
        scan(tbl[0].smp, d, -1, tbl[0].exp0, tbl[0].exp1);

        // Reset in the middle of a conversion.
        n = 0;
        while (!conv_start && n < 200) begin step(); n++; end
        step();
        reset = 1'b1;
        step();
        chk("midrst_conv_start", int'(conv_start), 0);
        chk("midrst_conv_channel", int'(conv_channel), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_channel", int'(out_channel), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_timeout_err", int'(timeout_err), 0);
        chk("midrst_overrun", int'(overrun), 0);
        reset = 1'b0; enable = 1'b0;
        ovr_exp = 0; te_exp = 0;
        conv_done = 1'b1; conv_data = 16'sd500;
        step();
        conv_done = 1'b0;
        step();
        chk("stale_done_valid", int'(out_valid), 0);
        chk("stale_done_busy", int'(busy), 0);
        chk("stale_valid_count", ov_count, ov_exp);
        enable = 1'b1;
        next_start = cyc + 1;
        scan(tbl[1].smp, d, -1, tbl[1].exp0, tbl[1].exp1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
